word_reveal_display: RTL and testbench

// - Consumer end of the guess-checker interface: takes per-position hit strobes and miss strobes,

---
 rtl/word_reveal_display.sv | 219 +++++++++++++++++++++
 tb/tb_word_reveal_display.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_reveal_display.sv
// Hangman word display: tracks revealed letter positions and misses for the
// current word, runs the IDLE/PLAYING/WON/LOST game FSM and drives the
// letter 7-seg digits, the miss-count digit and the LED bar.
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   new_game       pulse: latch word_letters/word_len, clear progress
//   word_letters   5-bit letter code per position (A=0..Z=25)
//   word_len       active positions (clamped to NUM_POS)
//   hit_valid      strobe qualifying hit_mask
//   hit_mask       positions matched by the current guess
//   miss_valid     strobe: current guess matched nothing
//   hex_letters    active-low {g..a} segments per position
//   hex_status     active-low hex digit of the miss count
//   ledr           [MAX_MISSES-1:0] miss thermometer, [8] lost, [9] won
//   game_state     0 IDLE, 1 PLAYING, 2 WON, 3 LOST
//
// Optional feature: define HANGMAN_BLINK_EN to blink the letters in WON/LOST.
module word_reveal_display #(
  parameter int unsigned NUM_POS    = 5,
  parameter int unsigned MAX_MISSES = 6,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 new_game,
  input  logic [5*NUM_POS-1:0] word_letters,
  input  logic [2:0]           word_len,
  input  logic                 hit_valid,
  input  logic [NUM_POS-1:0]   hit_mask,
  input  logic                 miss_valid,
  output logic [7*NUM_POS-1:0] hex_letters,
  output logic [6:0]           hex_status,
  output logic [9:0]           ledr,
  output logic [1:0]           game_state
);

  localparam int unsigned WORD_W = 5 * NUM_POS;
  localparam int unsigned HEX_W  = 7 * NUM_POS;
  localparam int unsigned MISS_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    WON     = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   word;
  logic [NUM_POS-1:0]  len_mask;
  logic [NUM_POS-1:0]  mask;
  logic [MISS_W-1:0]   misses;

  logic [2:0]          len_clamped;
  logic [NUM_POS-1:0]  len_mask_new;
  logic [NUM_POS-1:0]  mask_next;
  logic [MISS_W-1:0]   misses_next;
  logic                blank_all;

  logic [HEX_W-1:0]    hex_next;
  logic [6:0]          status_next;
  logic [9:0]          ledr_next;

  // Letter glyphs, active-low {g,f,e,d,c,b,a}; codes above Z are blank.
  function automatic logic [6:0] letter_glyph(input logic [4:0] code);
    case (code)
      5'd0:  letter_glyph = 7'b000_1000; // A
      5'd1:  letter_glyph = 7'b000_0011; // b
      5'd2:  letter_glyph = 7'b100_0110; // C
      5'd3:  letter_glyph = 7'b010_0001; // d
      5'd4:  letter_glyph = 7'b000_0110; // E
      5'd5:  letter_glyph = 7'b000_1110; // F
      5'd6:  letter_glyph = 7'b100_0010; // G
      5'd7:  letter_glyph = 7'b000_1001; // H
      5'd8:  letter_glyph = 7'b111_1001; // I
      5'd9:  letter_glyph = 7'b110_0001; // J
      5'd10: letter_glyph = 7'b000_1010; // K
      5'd11: letter_glyph = 7'b100_0111; // L
      5'd12: letter_glyph = 7'b110_1010; // M
      5'd13: letter_glyph = 7'b010_1011; // n
      5'd14: letter_glyph = 7'b100_0000; // O
      5'd15: letter_glyph = 7'b000_1100; // P
      5'd16: letter_glyph = 7'b001_1000; // q
      5'd17: letter_glyph = 7'b010_1111; // r
      5'd18: letter_glyph = 7'b001_0010; // S
      5'd19: letter_glyph = 7'b000_0111; // t
      5'd20: letter_glyph = 7'b100_0001; // U
      5'd21: letter_glyph = 7'b110_0011; // v
      5'd22: letter_glyph = 7'b101_0101; // W
      5'd23: letter_glyph = 7'b011_0110; // X
      5'd24: letter_glyph = 7'b001_0001; // Y
      5'd25: letter_glyph = 7'b010_0100; // Z
      default: letter_glyph = 7'h7F;
    endcase
  endfunction

  // Board hex decoder encoding, active-low.
  function automatic logic [6:0] hex_digit(input logic [3:0] val);
    case (val)
      4'h0: hex_digit = 7'h40;
      4'h1: hex_digit = 7'h79;
      4'h2: hex_digit = 7'h24;
      4'h3: hex_digit = 7'h30;
      4'h4: hex_digit = 7'h19;
      4'h5: hex_digit = 7'h12;
      4'h6: hex_digit = 7'h02;
      4'h7: hex_digit = 7'h78;
      4'h8: hex_digit = 7'h00;
      4'h9: hex_digit = 7'h10;
      4'hA: hex_digit = 7'h08;
      4'hB: hex_digit = 7'h03;
      4'hC: hex_digit = 7'h46;
      4'hD: hex_digit = 7'h21;
      4'hE: hex_digit = 7'h06;
      default: hex_digit = 7'h0E;
    endcase
  endfunction

  // Clamp the word length and expand it into a position mask.
  always_comb begin
    len_clamped  = (word_len > 3'(NUM_POS)) ? 3'(NUM_POS) : word_len;
    len_mask_new = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      len_mask_new[i] = (3'(i) < len_clamped);
    end
  end

  // Progress update for one PLAYING cycle; a hit wins over a simultaneous miss.
  always_comb begin
    mask_next   = mask;
    misses_next = misses;
    if (hit_valid) begin
      mask_next = mask | (hit_mask & len_mask);
    end else if (miss_valid && (misses != MISS_W'(MAX_MISSES))) begin
      misses_next = misses + MISS_W'(1);
    end
  end

  // Game FSM and progress registers; win/lose evaluated on the updated values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      word     <= '0;
      len_mask <= '0;
      mask     <= '0;
      misses   <= '0;
    end else if (new_game) begin
      state    <= PLAYING;
      word     <= word_letters;
      len_mask <= len_mask_new;
      mask     <= '0;
      misses   <= '0;
    end else if (state == PLAYING) begin
      mask   <= mask_next;
      misses <= misses_next;
      if ((mask_next & len_mask) == len_mask) begin
        state <= WON;
      end else if (misses_next == MISS_W'(MAX_MISSES)) begin
        state <= LOST;
      end
    end
  end

`ifdef HANGMAN_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
    end
  end

  assign blank_all = ((state == WON) || (state == LOST)) && blink_cnt[BLINK_BITS-1];
`else
  assign blank_all = 1'b0;
`endif

  // Next display image from the current game state.
  always_comb begin
    hex_next = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (!len_mask[i] || blank_all) begin
        hex_next[7*i +: 7] = 7'h7F;
      end else if ((state == PLAYING) && !mask[i]) begin
        hex_next[7*i +: 7] = 7'b011_1111;
      end else begin
        hex_next[7*i +: 7] = letter_glyph(word[5*i +: 5]);
      end
    end

    status_next = hex_digit(misses);

    ledr_next = '0;
    for (int i = 0; i < 8; i++) begin
      ledr_next[i] = (i < int'(MAX_MISSES)) && (MISS_W'(i) < misses);
    end
    ledr_next[8] = (state == LOST);
    ledr_next[9] = (state == WON);
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_letters <= {HEX_W{1'b1}};
      hex_status  <= 7'h40;
      ledr        <= '0;
      game_state  <= 2'd0;
    end else begin
      hex_letters <= hex_next;
      hex_status  <= status_next;
      ledr        <= ledr_next;
      game_state  <= state;
    end
  end

endmodule

// File: tb/tb_word_reveal_display.sv
// Self-checking bench for word_reveal_display: directed game scenarios plus
// randomized play, compared cycle by cycle against a behavioural game model.
module tb_word_reveal_display;

  logic        clk;
  logic        resetn;
  logic        new_game;
  logic [24:0] word_letters;
  logic [2:0]  word_len;
  logic        hit_valid;
  logic [4:0]  hit_mask;
  logic        miss_valid;
  logic [34:0] hex_letters;
  logic [6:0]  hex_status;
  logic [9:0]  ledr;
  logic [1:0]  game_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural game model
  int          m_state;
  int          m_mask;
  int          m_misses;
  int          m_len;
  logic [24:0] m_word;

  logic [34:0] exp_hex;
  logic [6:0]  exp_status;
  logic [9:0]  exp_ledr;
  logic [1:0]  exp_state;

  localparam logic [24:0] STAY = {5'd0, 5'd24, 5'd0, 5'd19, 5'd18};

  word_reveal_display dut (
    .clk          (clk),
    .resetn       (resetn),
    .new_game     (new_game),
    .word_letters (word_letters),
    .word_len     (word_len),
    .hit_valid    (hit_valid),
    .hit_mask     (hit_mask),
    .miss_valid   (miss_valid),
    .hex_letters  (hex_letters),
    .hex_status   (hex_status),
    .ledr         (ledr),
    .game_state   (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int code);
    case (code)
      0:       ref_glyph = 7'b000_1000;
      18:      ref_glyph = 7'b001_0010;
      19:      ref_glyph = 7'b000_0111;
      24:      ref_glyph = 7'b001_0001;
      default: ref_glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input int v);
    case (v)
      0: ref_digit = 7'h40;
      1: ref_digit = 7'h79;
      2: ref_digit = 7'h24;
      3: ref_digit = 7'h30;
      4: ref_digit = 7'h19;
      5: ref_digit = 7'h12;
      6: ref_digit = 7'h02;
      default: ref_digit = 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_mask   = 0;
    m_misses = 0;
    m_len    = 0;
    m_word   = '0;
  endtask

  // What the display should show for the current model state.
  task automatic model_display();
    for (int i = 0; i < 5; i++) begin
      if (i >= m_len)
        exp_hex[7*i +: 7] = 7'h7F;
      else if (m_state == 1 && ((m_mask >> i) & 1) == 0)
        exp_hex[7*i +: 7] = 7'h3F;
      else
        exp_hex[7*i +: 7] = ref_glyph(int'(m_word[5*i +: 5]));
    end
    exp_status = ref_digit(m_misses);
    exp_ledr   = 10'((1 << m_misses) - 1);
    exp_ledr[8] = (m_state == 3);
    exp_ledr[9] = (m_state == 2);
    exp_state  = 2'(m_state);
  endtask

  // Game rules applied for one clock edge.
  task automatic model_edge(input logic ng, input logic [24:0] wl, input int wlen,
                            input logic hv, input int hm, input logic mv);
    int full;
    if (ng) begin
      m_word   = wl;
      m_len    = (wlen > 5) ? 5 : wlen;
      m_state  = 1;
      m_mask   = 0;
      m_misses = 0;
    end else if (m_state == 1) begin
      full = (1 << m_len) - 1;
      if (hv) m_mask = m_mask | (hm & full);
      else if (mv && m_misses < 6) m_misses = m_misses + 1;
      if ((m_mask & full) == full) m_state = 2;
      else if (m_misses == 6) m_state = 3;
    end
  endtask

  task automatic drive_cycle(input logic ng, input logic [24:0] wl, input int wlen,
                             input logic hv, input int hm, input logic mv);
    @(negedge clk);
    new_game     = ng;
    word_letters = wl;
    word_len     = 3'(wlen);
    hit_valid    = hv;
    hit_mask     = 5'(hm);
    miss_valid   = mv;
    model_display();
    model_edge(ng, wl, wlen, hv, hm, mv);
    @(posedge clk);
    #1;
    check("hex_letters", 64'(hex_letters), 64'(exp_hex));
    check("hex_status",  64'(hex_status),  64'(exp_status));
    check("ledr",        64'(ledr),        64'(exp_ledr));
    check("game_state",  64'(game_state),  64'(exp_state));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, STAY, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic hit(input int hm);
    drive_cycle(1'b0, STAY, 0, 1'b1, hm, 1'b0);
  endtask

  task automatic miss();
    drive_cycle(1'b0, STAY, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hex"},    64'(hex_letters), 64'({5{7'h7F}}));
    check({tag, "_status"}, 64'(hex_status),  64'(7'h40));
    check({tag, "_ledr"},   64'(ledr),        64'(0));
    check({tag, "_state"},  64'(game_state),  64'(0));
  endtask

  initial begin
    logic [24:0] rw;
    int pool [10] = '{0, 18, 19, 24, 26, 27, 28, 29, 30, 31};

    resetn = 1'b0; new_game = 1'b0; word_letters = '0; word_len = '0;
    hit_valid = 1'b0; hit_mask = '0; miss_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    resetn = 1'b1;
    idle(1);

    // New game STAY: four dashes, HEX4 blank, zero misses.
    drive_cycle(1'b1, STAY, 4, 1'b0, 0, 1'b0);
    idle(1);
    check("start_hex", 64'(hex_letters), 64'({7'h7F, {4{7'h3F}}}));
    check("start_status", 64'(hex_status), 64'(7'h40));

    // Reveal A, then re-hit it.
    hit(5'b00100);
    idle(1);
    check("hex2_A", 64'(hex_letters[20:14]), 64'(7'b000_1000));
    hit(5'b00100);
    idle(1);
    check("rehit_misses", 64'(hex_status), 64'(7'h40));

    // Six misses lose the game; later hits ignored.
    for (int k = 0; k < 6; k++) miss();
    idle(1);
    check("lost_thermo", 64'(ledr[5:0]), 64'(6'h3F));
    check("lost_led", 64'(ledr[8]), 64'(1));
    check("lost_state", 64'(game_state), 64'(3));
    check("lost_letters", 64'(hex_letters[27:0]), 64'({7'b001_0001, 7'b000_1000, 7'b000_0111, 7'b001_0010}));
    hit(5'b11111);
    miss();
    idle(2);

    // Winning game.
    drive_cycle(1'b1, STAY, 4, 1'b0, 0, 1'b0);
    hit(5'b00100);
    hit(5'b00001);
    hit(5'b00010);
    hit(5'b01000);
    idle(1);
    check("won_state", 64'(game_state), 64'(2));
    check("won_led", 64'(ledr[9]), 64'(1));

    // new_game beats a same-cycle hit; hit beats a same-cycle miss.
    drive_cycle(1'b1, STAY, 4, 1'b1, 5'b00100, 1'b0);
    idle(1);
    check("ng_hit_dash", 64'(hex_letters[20:14]), 64'(7'h3F));
    drive_cycle(1'b0, STAY, 0, 1'b1, 5'b00100, 1'b1);
    idle(1);
    check("hit_miss_A", 64'(hex_letters[20:14]), 64'(7'b000_1000));
    check("hit_miss_cnt", 64'(hex_status), 64'(7'h40));

    // Asynchronous reset mid-game.
    miss();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    idle(1);

    // Zero-length word wins by itself; oversize length clamps.
    drive_cycle(1'b1, STAY, 0, 1'b0, 0, 1'b0);
    idle(3);
    drive_cycle(1'b1, {5'd18, STAY[19:0]}, 7, 1'b0, 0, 1'b0);
    hit(5'b11111);
    idle(2);

    // Randomized play.
    for (int k = 0; k < 800; k++) begin
      for (int p = 0; p < 5; p++) rw[5*p +: 5] = 5'(pool[$urandom_range(0, 9)]);
      drive_cycle($urandom_range(0, 19) == 0, rw, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
